trace_checker_seq: RTL

//  Parametrised multi-channel stimulus player with a built-in run-length implication checker.

---
 rtl/trace_checker_seq.sv | 77 +++++++
 1 files changed

// File: rtl/trace_checker_seq.sv
// Multi-channel waveform player driven from string parameters, with a run-length
// implication checker: any channel's run of REP_c highs must be followed by sig[TGT] high.
module trace_checker_seq #(
    parameter int                      NCH   = 4,
    parameter int                      DEPTH = 32,
    parameter int                      MODE  = 0,
    parameter logic [NCH*DEPTH*8-1:0]  TRACE = {(NCH*DEPTH){8'h5F}},
    parameter logic [NCH*8-1:0]        REP   = {NCH{8'd0}},
    parameter int                      TGT   = NCH - 1
) (
    input  logic                       i_clock,
    input  logic                       i_resetn,
    input  logic                       i_run,
    input  logic                       i_restart,
    output logic [NCH-1:0]             o_sig,
    output logic [$clog2(DEPTH)-1:0]   o_step,
    output logic                       o_done,
    output logic [NCH-1:0]             o_hit,
    output logic                       o_fail
);

    localparam int             SW   = $clog2(DEPTH);
    localparam logic [SW-1:0]  LAST = SW'(DEPTH - 1);

    logic [SW-1:0]   r_step;
    logic [7:0]      r_cnt [NCH];
    logic            r_pending;
    logic            r_fail;

    logic [NCH-1:0]  w_sig;
    logic [NCH-1:0]  w_hit;

    // Channel 0 sits in the MSBs of TRACE/REP; step 0 is the leftmost character.
    always_comb begin
        w_sig = '0;
        w_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            w_sig[c] = (TRACE[8*(DEPTH*(NCH-1-c) + DEPTH-1-int'(r_step)) +: 8] == 8'h2D);
            w_hit[c] = (REP[8*(NCH-1-c) +: 8] != 8'd0) && w_sig[c] &&
                       (({1'b0, r_cnt[c]} + 9'd1) >= {1'b0, REP[8*(NCH-1-c) +: 8]});
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_resetn || i_restart) begin
            r_step    <= '0;
            r_pending <= 1'b0;
            r_fail    <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_cnt[c] <= 8'd0;
            end
        end else if (i_run) begin
            if (r_step != LAST) begin
                r_step <= r_step + 1'b1;
            end else if (MODE == 1) begin
                r_step <= '0;
            end
            // Counters keep running across wrap and while holding the last step.
            for (int c = 0; c < NCH; c++) begin
                if (!w_sig[c]) begin
                    r_cnt[c] <= 8'd0;
                end else if (r_cnt[c] != 8'hFF) begin
                    r_cnt[c] <= r_cnt[c] + 8'd1;
                end
            end
            r_pending <= |w_hit;
            r_fail    <= r_fail | (r_pending & ~w_sig[TGT]);
        end
    end

    assign o_sig  = w_sig;
    assign o_step = r_step;
    assign o_done = (MODE == 0) && (r_step == LAST);
    assign o_hit  = w_hit;
    assign o_fail = r_fail;

endmodule
